unidad_riesgos: RTL and testbench
=================================

# unidad_riesgos

Hazard and stall controller for the vector processor pipeline (IF, ID, EX, MEM, WB).
- Sits beside the decode stage and tracks the destination registers of instructions in EX, MEM and WB.
- Compares them with the sources of the instruction in ID.
- Stalls fetch/decode and inserts NOP bubbles into EX on read-after-write conflicts.
- Optionally produces operand-forwarding selects for the EX stage.

## Interface
Parameters:
- REG_ADDR_W, 4, register address width (same for vector and scalar files)
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction (opcode 4'b0000 is driven as id_valid=0)
- id_rdv  in  1  ID instruction reads vector sources (reg_rdv from control unit)
- id_rds  in  1  ID instruction reads scalar source (reg_rds)
- id_srcv_a, id_srcv_b  in  REG_ADDR_W  vector source addresses, meaningful when id_rdv=1
- id_srcs  in  REG_ADDR_W  scalar source address, meaningful when id_rds=1
- id_dst  in  REG_ADDR_W  destination address
- id_wrv, id_wrs  in  1  instruction writes vector / scalar file (reg_wrv / reg_wrs)
- id_load  in  1  result comes from memory (sel_data=1 with reg_wrv=1)
- flush  in  1  PC redirect; ID instruction is discarded
- stall  out  1  combinational; hold PC and IF/ID register
- bubble  out  1  combinational; EX receives NOP (opcode 4'b0000, all write enables 0)
- ex_fwd_a, ex_fwd_b, ex_fwd_s  out  2  registered operand selects for EX: 00 register file, 01 MEM stage, 10 WB stage, 11 reserved
- stall_count  out  CNT_W  number of stall cycles since reset, saturating

## Operation
- The scoreboard has three entries: EX, MEM and WB.
  - Each entry holds {valid, is_vec, is_scl, dst, is_load}.
  - Each clock, WB←MEM and MEM←EX.
  - EX←ID fields when the instruction advances (id_valid & ~stall & ~flush); otherwise EX←invalid.
- Match on stage S, for each source:
  - Vector sources: id_rdv & entry.valid & entry.is_vec & (src == entry.dst).
  - Scalar source: id_rds & entry.valid & entry.is_scl & (id_srcs == entry.dst).
- The register file is write-through: a WB-stage writer is visible to an ID read in the same cycle, so WB matches never stall.
- Base behaviour (no forwarding): stall = id_valid & ~flush & (any match in EX or MEM).
- bubble = stall | flush | ~id_valid.
- ex_fwd_* are loaded with 00 whenever EX loads.
- stall_count increments on every cycle with stall=1 and holds at all ones.
- Simultaneous events:
  - flush overrides stall: stall=0, bubble=1.
  - With several matching stages, the youngest producer (EX before MEM) decides.
- Writes to vector and scalar files with equal addresses never conflict; the is_vec/is_scl class must match.

## Timing
- Reset values: all entries invalid, ex_fwd_*=00, stall_count=0, hence stall=0 and bubble=~id_valid.
- Reset mid-operation clears all entries on that edge; pending hazards vanish the next cycle.
- stall and bubble have zero latency: they are combinational from the ID inputs and scoreboard state.
- RAW distance 1 without forwarding: 2 stall cycles.
- RAW distance 2 without forwarding: 1 stall cycle.
- RAW distance 3 or more: 0 stall cycles.
- ex_fwd_* are valid in the same cycle the consumer occupies EX.

## Configuration
- Macro: RIESGOS_FWD_EN.
- Defined: forwarding is enabled.
  - A producer in EX that is not a load gives the consumer fwd=01 (producer will be in MEM); no stall.
  - A producer in MEM gives fwd=10; no stall.
  - A load producer in EX stalls 1 cycle, then resolves through MEM with fwd=10.
  - stall = id_valid & ~flush & (load match in EX).
- Undefined: ex_fwd_* tied to 00 and the base stall rule applies.

## Test plan
- Reset, then id_valid=1 with no writers in flight: stall=0, bubble=0, ex_fwd_*=00, stall_count=0.
- Without fwd: vector writer to V3, then a reader of id_srcv_a=3 the next cycle: stall=1 for exactly 2 cycles, stall_count=2, the consumer enters EX on the 3rd cycle.
- With RIESGOS_FWD_EN: ALU writer to V3, then consumer srcv_b=3: no stall, ex_fwd_b=01. A load to V3, then consumer srcv_a=3: 1 stall, then ex_fwd_a=10.
- Class and flush: scalar writer to S5, then vector reader of V5: no stall. Hazard stall with flush=1 in the same cycle: stall=0, bubble=1, EX entry invalid.
- Reset asserted during a 2-cycle stall: stall=0 the next cycle, stall_count=0, entries cleared. 2^CNT_W+5 forced stall cycles: stall_count holds at all ones.

Source files
------------

// File: rtl/unidad_riesgos.sv
// unidad_riesgos: RAW hazard / stall controller beside the decode stage.
// Tracks EX/MEM/WB destinations, stalls IF/ID and bubbles EX on conflicts.
// Optional macro RIESGOS_FWD_EN enables EX operand forwarding selects.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   id_*                  decoded ID instruction (valid, sources, dest, kind)
//   flush                 PC redirect, ID instruction discarded
//   stall, bubble         combinational pipeline controls
//   ex_fwd_a/b/s          registered EX operand selects (00 RF, 01 MEM, 10 WB)
//   stall_count           saturating count of stall cycles since reset
module unidad_riesgos #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic                  id_rdv,
    input  logic                  id_rds,
    input  logic [REG_ADDR_W-1:0] id_srcv_a,
    input  logic [REG_ADDR_W-1:0] id_srcv_b,
    input  logic [REG_ADDR_W-1:0] id_srcs,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_wrv,
    input  logic                  id_wrs,
    input  logic                  id_load,
    input  logic                  flush,
    output logic                  stall,
    output logic                  bubble,
    output logic [1:0]            ex_fwd_a,
    output logic [1:0]            ex_fwd_b,
    output logic [1:0]            ex_fwd_s,
    output logic [CNT_W-1:0]      stall_count
);

`ifdef RIESGOS_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef struct packed {
        logic                  valid;
        logic                  is_vec;
        logic                  is_scl;
        logic [REG_ADDR_W-1:0] dst;
        logic                  is_load;
    } entry_t;

    entry_t ex_q, ex_d;
    entry_t mem_q, mem_d;
    entry_t wb_q, wb_d;

    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [1:0]       fwd_s_q, fwd_s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic hit_v(entry_t e, logic rd, logic [REG_ADDR_W-1:0] src);
        return rd & e.valid & e.is_vec & (src == e.dst);
    endfunction

    function automatic logic hit_s(entry_t e, logic rd, logic [REG_ADDR_W-1:0] src);
        return rd & e.valid & e.is_scl & (src == e.dst);
    endfunction

    // Youngest producer wins. A WB producer needs no bypass because the
    // register file writes through to the same-cycle ID read.
    function automatic logic [1:0] pick(logic h_ex, logic h_mem, logic h_wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (h_ex) begin
            sel = 2'b01;
        end else if (h_mem) begin
            sel = 2'b10;
        end else if (h_wb) begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    logic ex_a, ex_b, ex_s;
    logic mem_a, mem_b, mem_s;
    logic wb_a, wb_b, wb_s;
    logic ex_hit, mem_hit, load_hit, raw, advance;

    always_comb begin
        ex_a  = hit_v(ex_q, id_rdv, id_srcv_a);
        ex_b  = hit_v(ex_q, id_rdv, id_srcv_b);
        ex_s  = hit_s(ex_q, id_rds, id_srcs);
        mem_a = hit_v(mem_q, id_rdv, id_srcv_a);
        mem_b = hit_v(mem_q, id_rdv, id_srcv_b);
        mem_s = hit_s(mem_q, id_rds, id_srcs);
        wb_a  = hit_v(wb_q, id_rdv, id_srcv_a);
        wb_b  = hit_v(wb_q, id_rdv, id_srcv_b);
        wb_s  = hit_s(wb_q, id_rds, id_srcs);

        ex_hit   = ex_a | ex_b | ex_s;
        mem_hit  = mem_a | mem_b | mem_s;
        // Load data only exists after MEM, so an EX load cannot be bypassed.
        load_hit = ex_hit & ex_q.is_load;
        raw      = FWD_EN ? load_hit : (ex_hit | mem_hit);

        stall   = id_valid & ~flush & raw;
        bubble  = stall | flush | ~id_valid;
        advance = id_valid & ~stall & ~flush;
    end

    always_comb begin
        ex_d    = '0;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        fwd_s_d = 2'b00;
        if (advance) begin
            ex_d.valid   = 1'b1;
            ex_d.is_vec  = id_wrv;
            ex_d.is_scl  = id_wrs;
            ex_d.dst     = id_dst;
            ex_d.is_load = id_load & id_wrv;
            if (FWD_EN) begin
                fwd_a_d = pick(ex_a, mem_a, wb_a);
                fwd_b_d = pick(ex_b, mem_b, wb_b);
                fwd_s_d = pick(ex_s, mem_s, wb_s);
            end
        end
        mem_d = ex_q;
        wb_d  = mem_q;
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
            fwd_s_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            fwd_s_q <= fwd_s_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_fwd_a    = fwd_a_q;
    assign ex_fwd_b    = fwd_b_q;
    assign ex_fwd_s    = fwd_s_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_unidad_riesgos.sv
// Scoreboard bench for unidad_riesgos: directed per-cycle vectors push
// expected outputs; a negedge monitor pops and compares.
module tb_unidad_riesgos;

    localparam int AW   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef RIESGOS_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          id_valid, id_rdv, id_rds;
    logic [AW-1:0] id_srcv_a, id_srcv_b, id_srcs, id_dst;
    logic          id_wrv, id_wrs, id_load, flush;
    logic          stall, bubble;
    logic [1:0]    ex_fwd_a, ex_fwd_b, ex_fwd_s;
    logic [CW-1:0] stall_count;

    unidad_riesgos #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rdv(id_rdv), .id_rds(id_rds),
        .id_srcv_a(id_srcv_a), .id_srcv_b(id_srcv_b), .id_srcs(id_srcs),
        .id_dst(id_dst), .id_wrv(id_wrv), .id_wrs(id_wrs),
        .id_load(id_load), .flush(flush),
        .stall(stall), .bubble(bubble),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .ex_fwd_s(ex_fwd_s),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v, rdv, rds, wrv, wrs, ld, fl, rst;
        int sa, sb, ss, dst;
    } in_t;

    typedef struct {
        string name;
        int st, bb, fa, fb, fs, cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   nstall   = 0;

    function automatic in_t nop();
        in_t i = '{default: 0};
        return i;
    endfunction

    function automatic in_t wr(int d, bit vec, bit ld);
        in_t i = '{default: 0};
        i.v = 1; i.wrv = vec; i.wrs = !vec; i.ld = ld; i.dst = d;
        return i;
    endfunction

    function automatic in_t rv(int a, int b);
        in_t i = '{default: 0};
        i.v = 1; i.rdv = 1; i.sa = a; i.sb = b;
        return i;
    endfunction

    function automatic in_t rs(int s);
        in_t i = '{default: 0};
        i.v = 1; i.rds = 1; i.ss = s;
        return i;
    endfunction

    // Drive one ID cycle and queue the outputs expected during that cycle.
    task automatic cyc(string nm, in_t i, int st, int bb, int fa, int fb, int fs);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = i.rst;
        id_valid  = i.v;
        id_rdv    = i.rdv;
        id_rds    = i.rds;
        id_srcv_a = i.sa[AW-1:0];
        id_srcv_b = i.sb[AW-1:0];
        id_srcs   = i.ss[AW-1:0];
        id_dst    = i.dst[AW-1:0];
        id_wrv    = i.wrv;
        id_wrs    = i.wrs;
        id_load   = i.ld;
        flush     = i.fl;
        e = '{nm, st, bb, fa, fb, fs, (nstall > CMAX) ? CMAX : nstall};
        q.push_back(e);
        if (i.rst) nstall = 0;
        else if (st == 1) nstall++;
    endtask

    task automatic chk(string nm, string f, int act, int exp);
        if (exp >= 0) begin
            checks++;
            if (act != exp) begin
                failures++;
                $display("FAIL %s.%s actual=%0d required=%0d", nm, f, act, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk(e.name, "stall", int'(stall), e.st);
            chk(e.name, "bubble", int'(bubble), e.bb);
            chk(e.name, "fwd_a", int'(ex_fwd_a), e.fa);
            chk(e.name, "fwd_b", int'(ex_fwd_b), e.fb);
            chk(e.name, "fwd_s", int'(ex_fwd_s), e.fs);
            chk(e.name, "count", int'(stall_count), e.cnt);
        end
    end

    initial begin
        in_t x;
        int  st;
        reset = 1'b1;
        id_valid = 0; id_rdv = 0; id_rds = 0;
        id_srcv_a = '0; id_srcv_b = '0; id_srcs = '0; id_dst = '0;
        id_wrv = 0; id_wrs = 0; id_load = 0; flush = 0;
        repeat (2) @(posedge clk);

        // Reset state, then a RAW distance-1 on V3
        x = rv(1, 2); x.rds = 1; x.ss = 1;
        cyc("reset_idle", x, 0, 0, 0, 0, 0);
        cyc("a_wr_v3", wr(3, 1, 0), 0, 0, 0, 0, 0);
        cyc("a_rd1", rv(3, 0), FWD ? 0 : 1, FWD ? 0 : 1, 0, 0, 0);
        cyc("a_rd2", rv(3, 0), FWD ? 0 : 1, FWD ? 0 : 1, FWD ? 1 : 0, 0, 0);
        cyc("a_rd3", rv(3, 0), 0, 0, FWD ? 2 : 0, 0, 0);
        cyc("a_nop", nop(), 0, 1, 0, 0, 0);

        // ALU producer read through source b
        cyc("w_wr_v6", wr(6, 1, 0), 0, 0, 0, 0, 0);
        cyc("w_rd", rv(0, 6), FWD ? 0 : 1, FWD ? 0 : 1, -1, -1, -1);
        cyc("w_nop", nop(), 0, 1, 0, FWD ? 1 : 0, 0);

        // Load producer: always one stall, then WB-stage bypass
        cyc("l_ld_v4", wr(4, 1, 1), 0, 0, 0, 0, 0);
        cyc("l_rd1", rv(4, 0), 1, 1, -1, -1, -1);
        cyc("l_rd2", rv(4, 0), FWD ? 0 : 1, FWD ? 0 : 1, -1, -1, -1);
        cyc("l_rd3", rv(4, 0), 0, 0, FWD ? 2 : 0, 0, 0);
        cyc("l_nop", nop(), 0, 1, 0, 0, 0);

        // Scalar writer vs vector reader of same address; then scalar RAW
        cyc("c_wr_s5", wr(5, 0, 0), 0, 0, -1, -1, -1);
        cyc("c_rv5", rv(5, 5), 0, 0, -1, -1, -1);
        cyc("c_rs5", rs(5), FWD ? 0 : 1, FWD ? 0 : 1, -1, -1, -1);
        cyc("c_nop", nop(), 0, 1, 0, 0, FWD ? 2 : 0);

        // Flush beats a hazard; flushed writer must not reach EX
        cyc("f_wr_v7", wr(7, 1, 0), 0, 0, -1, -1, -1);
        x = rv(7, 7); x.wrv = 1; x.dst = 9; x.fl = 1;
        cyc("f_flush", x, 0, 1, -1, -1, -1);
        cyc("f_rd_v9", rv(9, 9), 0, 0, -1, -1, -1);
        cyc("f_nop", nop(), 0, 1, 0, 0, 0);

        // Two producers in flight: youngest (EX) decides
        cyc("p_wr1", wr(8, 1, 0), 0, 0, -1, -1, -1);
        cyc("p_wr2", wr(8, 1, 0), 0, 0, -1, -1, -1);
        cyc("p_rd", rv(8, 0), FWD ? 0 : 1, FWD ? 0 : 1, -1, -1, -1);
        cyc("p_nop", nop(), 0, 1, FWD ? 1 : 0, 0, 0);

        // Reset in the middle of a stall
        cyc("r_ld_v3", wr(3, 1, 1), 0, 0, -1, -1, -1);
        x = rv(3, 0); x.rst = 1;
        cyc("r_rd_rst", x, 1, 1, -1, -1, -1);
        cyc("r_after", rv(3, 0), 0, 0, 0, 0, 0);

        // Saturation of the stall counter
        x = nop(); x.rst = 1;
        cyc("s_reset", x, 0, 1, -1, -1, -1);
        x = rv(3, 3); x.wrv = 1; x.dst = 3; x.ld = 1;
        for (int k = 0; k < 60; k++) begin
            st = FWD ? ((k % 2) == 1) : ((k % 3) != 0);
            cyc("s_loop", x, st, st, -1, -1, -1);
        end
        cyc("s_hold", nop(), 0, 1, -1, -1, -1);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
